sawtooth_run_ctrl: RTL and testbench

Run controller for the sawtooth counter datapath. It turns synchronised select/start button levels into edge events, sequences loading of the bounds N1 and N2 from the switch bus, and validates them. It then steps the sawtooth value from N1 to N2 on each divider tick, wrapping back to N1, and stops after a programmable number of periods. It sits between the input synchronisers/clock-divider tick and the BCD/LED display path, and drives the debug state digit.

---
 rtl/sawtooth_run_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_sawtooth_run_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sawtooth_run_ctrl.sv
// Run controller for the sawtooth counter: it loads the bounds, validates them, steps the count and stops after a set number of periods.
// Optional feature macro: SAWTOOTH_CTRL_AUTOSWAP_EN (swap reversed bounds on start instead of raising an error).
module sawtooth_run_ctrl #(
    parameter int WIDTH   = 8,
    parameter int PERIODS = 0,
    parameter int PER_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             v_i,
    input  logic             st_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] n1_o,
    output logic [WIDTH-1:0] n2_o,
    output logic [WIDTH-1:0] cnt_o,
    output logic             run_o,
    output logic             wrap_o,
    output logic             err_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_N1    = 3'd1,
        S_N2    = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [PER_W-1:0] PERIODS_L = PER_W'(PERIODS);

    state_t           r_state;
    logic             r_v_q;
    logic             r_st_q;
    logic [PER_W-1:0] r_per;
    logic [WIDTH-1:0] r_n1;
    logic [WIDTH-1:0] r_n2;
    logic [WIDTH-1:0] r_cnt;
    logic             r_run;
    logic             r_wrap;
    logic             r_err;

    logic             w_v_rise;
    logic             w_st_rise;
    logic [PER_W-1:0] w_per_next;
    logic             w_period_done;

    // Delay registers reset high so a button held through reset must be released first.
    assign w_v_rise      = v_i & ~r_v_q;
    assign w_st_rise     = st_i & ~r_st_q;
    assign w_per_next    = r_per + 1'b1;
    assign w_period_done = (PERIODS != 0) && (w_per_next == PERIODS_L);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_v_q   <= 1'b1;
            r_st_q  <= 1'b1;
            r_per   <= '0;
            r_n1    <= '0;
            r_n2    <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_v_q  <= v_i;
            r_st_q <= st_i;
            r_wrap <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_v_rise) begin
                        r_n1    <= din_i;
                        r_state <= S_N1;
                    end
                end
                S_N1: begin
                    if (w_v_rise) begin
                        r_n2    <= din_i;
                        r_state <= S_N2;
                    end
                end
                S_N2: begin
                    if (w_v_rise) begin
                        r_n1    <= din_i;
                        r_state <= S_N1;
                    end else if (w_st_rise) begin
                        if (r_n1 < r_n2) begin
                            r_cnt   <= r_n1;
                            r_per   <= '0;
                            r_run   <= 1'b1;
                            r_state <= S_RUN;
`ifdef SAWTOOTH_CTRL_AUTOSWAP_EN
                        end else if (r_n1 > r_n2) begin
                            r_n1    <= r_n2;
                            r_n2    <= r_n1;
                            r_cnt   <= r_n2;
                            r_per   <= '0;
                            r_run   <= 1'b1;
                            r_state <= S_RUN;
`endif
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_RUN: begin
                    // A pause request takes precedence over a coincident tick.
                    if (w_st_rise) begin
                        r_run   <= 1'b0;
                        r_state <= S_PAUSE;
                    end else if (tick_i) begin
                        if (r_cnt == r_n2) begin
                            r_per <= w_per_next;
                            if (w_period_done) begin
                                r_run   <= 1'b0;
                                r_state <= S_DONE;
                            end else begin
                                r_cnt  <= r_n1;
                                r_wrap <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (w_v_rise) begin
                        r_n1    <= '0;
                        r_n2    <= '0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_st_rise) begin
                        r_run   <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (w_v_rise) begin
                        r_n1    <= '0;
                        r_n2    <= '0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_st_rise) begin
                        r_cnt   <= r_n1;
                        r_per   <= '0;
                        r_run   <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_ERR: begin
                    if (w_v_rise) begin
                        r_n1    <= '0;
                        r_n2    <= '0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_run   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign n1_o    = r_n1;
    assign n2_o    = r_n2;
    assign cnt_o   = r_cnt;
    assign run_o   = r_run;
    assign wrap_o  = r_wrap;
    assign err_o   = r_err;
    assign state_o = r_state;

endmodule

// File: tb/tb_sawtooth_run_ctrl.sv
// Directed bench for sawtooth_run_ctrl (PERIODS=2): a cycle table for load/run/auto-stop plus hand-written corner sequences.
module tb_sawtooth_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       tick_i;
    logic       v_i;
    logic       st_i;
    logic [7:0] din_i;
    logic [7:0] n1_o;
    logic [7:0] n2_o;
    logic [7:0] cnt_o;
    logic       run_o;
    logic       wrap_o;
    logic       err_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wraps  = 0;

    always #5 clk = ~clk;

    sawtooth_run_ctrl #(.WIDTH(8), .PERIODS(2), .PER_W(8)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .tick_i (tick_i),
        .v_i    (v_i),
        .st_i   (st_i),
        .din_i  (din_i),
        .n1_o   (n1_o),
        .n2_o   (n2_o),
        .cnt_o  (cnt_o),
        .run_o  (run_o),
        .wrap_o (wrap_o),
        .err_o  (err_o),
        .state_o(state_o)
    );

    typedef struct {
        logic       v;
        logic       st;
        logic       tick;
        logic [7:0] din;
        logic [2:0] e_state;
        logic [7:0] e_n1;
        logic [7:0] e_n2;
        logic [7:0] e_cnt;
        logic       e_run;
        logic       e_wrap;
        logic       e_err;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] s, input logic [7:0] n1,
                             input logic [7:0] n2, input logic [7:0] c, input logic r,
                             input logic w, input logic e);
        check({tag, ".state"}, 32'(state_o), 32'(s));
        check({tag, ".n1"},    32'(n1_o),    32'(n1));
        check({tag, ".n2"},    32'(n2_o),    32'(n2));
        check({tag, ".cnt"},   32'(cnt_o),   32'(c));
        check({tag, ".run"},   32'(run_o),   32'(r));
        check({tag, ".wrap"},  32'(wrap_o),  32'(w));
        check({tag, ".err"},   32'(err_o),   32'(e));
    endtask

    // Advance one clock edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive button levels for one edge, then release for one edge.
    task automatic press(input logic pv, input logic pst, input logic [7:0] d);
        v_i   = pv;
        st_i  = pst;
        din_i = d;
        step();
        v_i  = 1'b0;
        st_i = 1'b0;
        step();
    endtask

    initial begin
        //              v   st  tk  din    state  n1     n2     cnt    run wrap err
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'd5, 3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'd5, 3'd1, 8'd5, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'd8, 3'd1, 8'd5, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'd8, 3'd2, 8'd5, 8'd8, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd2, 8'd5, 8'd8, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'd0, 3'd3, 8'd5, 8'd8, 8'd5, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd3, 8'd5, 8'd8, 8'd6, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd3, 8'd5, 8'd8, 8'd7, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd3, 8'd5, 8'd8, 8'd8, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd3, 8'd5, 8'd8, 8'd5, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd3, 8'd5, 8'd8, 8'd6, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd3, 8'd5, 8'd8, 8'd7, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd3, 8'd5, 8'd8, 8'd8, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd5, 8'd5, 8'd8, 8'd8, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd5, 8'd5, 8'd8, 8'd8, 1'b0, 1'b0, 1'b0};

        rst_i  = 1'b1;
        tick_i = 1'b0;
        v_i    = 1'b0;
        st_i   = 1'b0;
        din_i  = 8'd0;
        step();
        step();
        check_all("reset", 3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;

        // Load 5/8, start with free ticks, run two periods to auto-stop.
        for (int i = 0; i < 15; i++) begin
            v_i    = tbl[i].v;
            st_i   = tbl[i].st;
            tick_i = tbl[i].tick;
            din_i  = tbl[i].din;
            step();
            if (wrap_o === 1'b1) n_wraps++;
            check_all($sformatf("tbl[%0d]", i), tbl[i].e_state, tbl[i].e_n1, tbl[i].e_n2,
                      tbl[i].e_cnt, tbl[i].e_run, tbl[i].e_wrap, tbl[i].e_err);
        end
        check("wrap_pulses", 32'(n_wraps), 32'd1);
        tick_i = 1'b0;

        // Restart from DONE, pause at 6, ticks ignored, resume.
        press(1'b0, 1'b1, 8'd0);
        check_all("restart", 3'd3, 8'd5, 8'd8, 8'd5, 1'b1, 1'b0, 1'b0);
        tick_i = 1'b1; step(); tick_i = 1'b0;
        check("restart.cnt6", 32'(cnt_o), 32'd6);
        press(1'b0, 1'b1, 8'd0);
        check_all("pause", 3'd4, 8'd5, 8'd8, 8'd6, 1'b0, 1'b0, 1'b0);
        tick_i = 1'b1;
        repeat (10) step();
        tick_i = 1'b0;
        check_all("pause_ticks", 3'd4, 8'd5, 8'd8, 8'd6, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 8'd0);
        check_all("resume", 3'd3, 8'd5, 8'd8, 8'd6, 1'b1, 1'b0, 1'b0);
        tick_i = 1'b1; step(); tick_i = 1'b0;
        check_all("resume_tick", 3'd3, 8'd5, 8'd8, 8'd7, 1'b1, 1'b0, 1'b0);

        // One-cycle reset mid-run.
        rst_i = 1'b1; step(); rst_i = 1'b0;
        check_all("midrun_rst", 3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        step();

        // Reversed bounds 9/3.
        press(1'b1, 1'b0, 8'd9);
        check_all("ld9", 3'd1, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 8'd3);
        check_all("ld3", 3'd2, 8'd9, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 8'd0);
`ifdef SAWTOOTH_CTRL_AUTOSWAP_EN
        check_all("swap", 3'd3, 8'd3, 8'd9, 8'd3, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 8'd0);
        check("swap.pause", 32'(state_o), 32'd4);
`else
        check_all("err", 3'd6, 8'd9, 8'd3, 8'd0, 1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 8'd0);
        check_all("err_st_ignored", 3'd6, 8'd9, 8'd3, 8'd0, 1'b0, 1'b0, 1'b1);
`endif
        press(1'b1, 1'b0, 8'd0);
        check_all("back_idle", 3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Button held through reset and after it is not an edge.
        v_i   = 1'b1;
        din_i = 8'h77;
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        repeat (5) step();
        check_all("held_v", 3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        v_i = 1'b0;
        step();
        press(1'b1, 1'b0, 8'h2A);
        check_all("after_release", 3'd1, 8'h2A, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Simultaneous v and st in N2_SET: reload N1, no run.
        press(1'b1, 1'b0, 8'h30);
        check("n2_load", 32'(n2_o), 32'h30);
        press(1'b1, 1'b1, 8'h11);
        check_all("v_st_same", 3'd1, 8'h11, 8'h30, 8'd0, 1'b0, 1'b0, 1'b0);

        // Equal bounds are always an error.
        press(1'b1, 1'b0, 8'h11);
        press(1'b0, 1'b1, 8'd0);
        check_all("equal_err", 3'd6, 8'h11, 8'h11, 8'd0, 1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 8'd0);
        check_all("equal_clear", 3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
